// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states and default width.
package serial_subtractor_pkg;

  // Controller states; DONE lasts a single cycle so done can pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand/result width used when the parent does not override it.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell, reused every BUSY cycle by the serial datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow for a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: captures a and b on start, processes one bit
// per cycle LSB first through a single full subtractor, and publishes diff,
// borrow_out and zero together with a one-cycle done pulse.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrowOut_q, borrowOut_d;
  logic             zero_q, zero_d;

  logic             diffBit;
  logic             borrowBit;
  logic [WIDTH:0]   partialExt;
  logic [WIDTH-1:0] partialNext;

  full_subtractor uCell (
    .a    (aShift_q[0]),
    .b    (bShift_q[0]),
    .bin  (borrow_q),
    .d    (diffBit),
    .bout (borrowBit)
  );

  // Partial result with the freshly computed bit shifted in at the MSB.
  always_comb begin
    partialExt  = {diffBit, partial_q};
    partialNext = partialExt[WIDTH:1];
  end

  // Next-state logic: capture on start, shift one bit per BUSY cycle, and
  // load the visible result registers on the transition into DONE.
  always_comb begin
    state_d     = state_q;
    aShift_d    = aShift_q;
    bShift_d    = bShift_q;
    partial_d   = partial_q;
    borrow_d    = borrow_q;
    bitCnt_d    = bitCnt_q;
    diff_d      = diff_q;
    borrowOut_d = borrowOut_q;
    zero_d      = zero_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          aShift_d  = a;
          bShift_d  = b;
          partial_d = '0;
          borrow_d  = 1'b0;
          bitCnt_d  = '0;
        end
      end
      BUSY: begin
        aShift_d  = aShift_q >> 1;
        bShift_d  = bShift_q >> 1;
        partial_d = partialNext;
        borrow_d  = borrowBit;
        bitCnt_d  = bitCnt_q + 1'b1;
        if (bitCnt_q == LAST_BIT) begin
          state_d     = DONE;
          diff_d      = partialNext;
          borrowOut_d = borrowBit;
          zero_d      = (partialNext == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aShift_q    <= '0;
      bShift_q    <= '0;
      partial_q   <= '0;
      borrow_q    <= 1'b0;
      bitCnt_q    <= '0;
      diff_q      <= '0;
      borrowOut_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      aShift_q    <= aShift_d;
      bShift_q    <= bShift_d;
      partial_q   <= partial_d;
      borrow_q    <= borrow_d;
      bitCnt_q    <= bitCnt_d;
      diff_q      <= diff_d;
      borrowOut_q <= borrowOut_d;
      zero_q      <= zero_d;
    end
  end

  // Outputs come straight from registers so they stay glitch-free.
  always_comb begin
    diff       = diff_q;
    borrow_out = borrowOut_q;
    zero       = zero_q;
    busy       = (state_q == BUSY);
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): the driver pushes the
// expected result for each accepted operation, a monitor pops on done.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] diff;
  logic       borrow_out;
  logic       zero;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       zero;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycleCount = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used for period checks.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per done pulse and checks the exclusivity of busy/done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL busyDoneOverlap: actual=busy=1,done=1 required=not both");
      end
      if (done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpectedDone: actual=done=1 required=no pending operation");
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkEq("diff", int'(diff), int'(e.diff));
          checkEq("borrow_out", int'(borrow_out), int'(e.borrow));
          checkEq("zero", int'(zero), int'(e.zero));
        end
      end
    end
  end

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.zero   = (e.diff == 8'h00);
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [7:0] d, input logic bo, input logic z);
    exp_t e;
    e.diff   = d;
    e.borrow = bo;
    e.zero   = z;
    return e;
  endfunction

  // Waits for IDLE, presents operands with a one-cycle start, returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input bit doPush, input exp_t e);
    int guard = 0;
    while ((busy || done) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleTimeout: actual=not idle required=idle within 50 cycles");
    end
    a     = av;
    b     = bv;
    start = 1'b1;
    if (doPush) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done to be visible; reports the number of edges waited.
  task automatic waitDone(output int waited);
    waited = 0;
    while (!done && waited < 30) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL doneTimeout: actual=no done required=done within 30 cycles");
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] d, input logic bo,
                             input logic z, input logic bz, input logic dn);
    checkEq({name, "_diff"}, int'(diff), int'(d));
    checkEq({name, "_borrow"}, int'(borrow_out), int'(bo));
    checkEq({name, "_zero"}, int'(zero), int'(z));
    checkEq({name, "_busy"}, int'(busy), int'(bz));
    checkEq({name, "_done"}, int'(done), int'(dn));
  endtask

  logic [7:0] dirA [9] = '{8'h5A, 8'h10, 8'h77, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h00, 8'hC3};
  logic [7:0] dirB [9] = '{8'h3C, 8'h20, 8'h77, 8'hFF, 8'h01, 8'h01, 8'h02, 8'h00, 8'h3C};
  logic [7:0] dirD [9] = '{8'h1E, 8'hF0, 8'h00, 8'h01, 8'hFE, 8'h7F, 8'hFF, 8'h00, 8'h87};
  logic       dirBo[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       dirZ [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int   waited;
    int   busyCnt;
    int   lastDone;
    exp_t dummy;
    logic [7:0] ra, rb;
    dummy = mkExp(8'h00, 1'b0, 1'b0);

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accept at edge 0, busy for 8 cycles, done visible after edge 8.
    applyStimulus(8'h5A, 8'h3C, 1'b1, mkExp(8'h1E, 1'b0, 1'b0));
    busyCnt = 0;
    waited  = 0;
    while (!done && waited < 30) begin
      if (busy) busyCnt++;
      if (diff !== 8'h00) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL diffDuringBusy: actual=0x%0h required=0x0", diff);
      end
      @(posedge clk); #1;
      waited++;
    end
    checkEq("latencyEdges", waited, 8);
    checkEq("busyCycles", busyCnt, 8);
    @(posedge clk); #1;
    checkEq("doneSingleCycle", int'(done), 0);

    // Directed table of hand-computed results.
    for (int i = 0; i < 9; i++)
      applyStimulus(dirA[i], dirB[i], 1'b1, mkExp(dirD[i], dirBo[i], dirZ[i]));

    // Start pulses and operand changes during BUSY must be ignored.
    applyStimulus(8'h5A, 8'h3C, 1'b1, mkExp(8'h1E, 1'b0, 1'b0));
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    checkEq("busyAfterIgnoredStart", int'(busy), 1);
    waitDone(waited);
    @(posedge clk); #1;

    // Start held high: back-to-back operations every 10 cycles.
    while ((busy || done)) begin @(posedge clk); #1; end
    a = 8'h9C; b = 8'h1D; start = 1'b1;
    sb.push_back(mkExp(8'h7F, 1'b0, 1'b0));
    waitDone(waited);
    lastDone = cycleCount;
    a = 8'h05; b = 8'h06;
    sb.push_back(mkExp(8'hFF, 1'b1, 1'b0));
    @(posedge clk); #1;
    waitDone(waited);
    checkEq("b2bPeriod1", cycleCount - lastDone, 10);
    lastDone = cycleCount;
    a = 8'hAA; b = 8'hAA;
    sb.push_back(mkExp(8'h00, 1'b0, 1'b1));
    @(posedge clk); #1;
    waitDone(waited);
    checkEq("b2bPeriod2", cycleCount - lastDone, 10);
    lastDone = cycleCount;
    a = 8'hF0; b = 8'h0F;
    sb.push_back(mkExp(8'hE1, 1'b0, 1'b0));
    @(posedge clk); #1;
    waitDone(waited);
    checkEq("b2bPeriod3", cycleCount - lastDone, 10);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset at edge 4 of an operation aborts it without a done pulse.
    applyStimulus(8'h12, 8'h34, 1'b0, dummy);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midReset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    applyStimulus(8'hFF, 8'h01, 1'b1, mkExp(8'hFE, 1'b0, 1'b0));
    waitDone(waited);
    @(posedge clk); #1;

    // Reset wins over a simultaneous start.
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'h33; b = 8'h11;
    @(posedge clk); #1;
    checkEq("resetPriorityBusy", int'(busy), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkEq("resetPriorityIdle", int'(busy), 0);

    // Random regression against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 1'b1, model(ra, rb));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    checkEq("scoreboardDrained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
